dmio_gpio: RTL and testbench

Parametrised data-memory and memory-mapped I/O block for the processor datapath, the next generation of the single-LED/single-switch data-memory port. Serves load/store accesses to an internal word RAM below `IO_BASE` and to a small register file above it. The register file provides LED output, debounced switch input, switch rising-edge capture and a maskable interrupt. Reads are registered, and a valid strobe accompanies them.

---
 rtl/dmio_gpio_if.sv | 23 ++
 rtl/dmio_gpio.sv | 134 +++++++++++++
 tb/tb_dmio_gpio.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmio_gpio_if.sv
// Load/store bus between the datapath and the data-memory / GPIO block.
// Master drives the access; slave returns registered load data with a valid strobe.
interface dmio_gpio_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_write;
  logic              enable_write;
  logic              enable_read;
  logic [DATA_W-1:0] data_read;
  logic              read_valid;

  modport master (
    output address, data_write, enable_write, enable_read,
    input  data_read, read_valid
  );

  modport slave (
    input  address, data_write, enable_write, enable_read,
    output data_read, read_valid
  );
endinterface

// File: rtl/dmio_gpio.sv
// Word RAM below IO_BASE plus LED / debounced-switch / edge-capture / IRQ registers above it.
// Loads are registered and read-first with respect to a same-cycle store.
module dmio_gpio #(
  parameter int unsigned       DATA_W          = 64,
  parameter int unsigned       ADDR_W          = 64,
  parameter int unsigned       MEM_DEPTH       = 256,
  parameter logic [ADDR_W-1:0] IO_BASE         = ADDR_W'(64'h1000),
  parameter int unsigned       N_LED           = 8,
  parameter int unsigned       N_SW            = 8,
  parameter int unsigned       DEBOUNCE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  dmio_gpio_if.slave      bus,
  input  logic [N_SW-1:0] SW,
  output logic [N_LED-1:0] LEDS,
  output logic            irq
);

  localparam int unsigned       IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned       CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] RAM_END = ADDR_W'(MEM_DEPTH * 8);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [N_LED-1:0]  leds_q;
  logic [N_SW-1:0]   sync1_q, sync2_q, stable_q, stable_d;
  logic [N_SW-1:0]   edge_q, edge_d, mask_q, rise, w1c;
  logic [CNT_W-1:0]  cnt_q [N_SW];
  logic [CNT_W-1:0]  cnt_d [N_SW];
  logic              irq_q, read_valid_q;
  logic [DATA_W-1:0] data_read_q, rd_data;

  logic              in_ram, in_io;
  logic [ADDR_W-1:0] io_off;
  logic [ADDR_W-4:0] io_word;
  logic [IDX_W-1:0]  word_idx;
  logic              sel_led, sel_sw, sel_edge, sel_mask;
  logic              unused_off_bits;

  assign in_ram   = bus.address < RAM_END;
  assign in_io    = bus.address >= IO_BASE;
  assign io_off   = bus.address - IO_BASE;
  assign io_word  = io_off[ADDR_W-1:3];
  assign word_idx = bus.address[IDX_W+2:3];
  assign sel_led  = in_io && (io_word == (ADDR_W-3)'(0));
  assign sel_sw   = in_io && (io_word == (ADDR_W-3)'(1));
  assign sel_edge = in_io && (io_word == (ADDR_W-3)'(2));
  assign sel_mask = in_io && (io_word == (ADDR_W-3)'(3));
  assign unused_off_bits = ^io_off[2:0];

  // Counter tracks consecutive cycles where sync2 disagrees with the accepted value.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_SW; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A fresh rising edge outranks a same-cycle write-one-to-clear.
  always_comb begin
    rise   = stable_d & ~stable_q;
    w1c    = (bus.enable_write && sel_edge) ? bus.data_write[N_SW-1:0] : '0;
    edge_d = (edge_q & ~w1c) | rise;
  end

  always_comb begin
    rd_data = '0;
    if (in_ram) begin
      rd_data = mem[word_idx];
    end else if (sel_led) begin
      rd_data = DATA_W'(leds_q);
    end else if (sel_sw) begin
      rd_data = DATA_W'(stable_q);
    end else if (sel_edge) begin
      rd_data = DATA_W'(edge_q);
    end else if (sel_mask) begin
      rd_data = DATA_W'(mask_q);
    end
  end

  // RAM contents survive reset; stores are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (!rst && bus.enable_write && in_ram) begin
      mem[word_idx] <= bus.data_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      leds_q       <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      edge_q       <= '0;
      mask_q       <= '0;
      cnt_q        <= '{default: '0};
      irq_q        <= 1'b0;
      read_valid_q <= 1'b0;
      data_read_q  <= '0;
    end else begin
      sync1_q      <= SW;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      edge_q       <= edge_d;
      irq_q        <= |(edge_q & mask_q);
      read_valid_q <= bus.enable_read;
      if (bus.enable_read) begin
        data_read_q <= rd_data;
      end
      if (bus.enable_write && sel_led) begin
        leds_q <= bus.data_write[N_LED-1:0];
      end
      if (bus.enable_write && sel_mask) begin
        mask_q <= bus.data_write[N_SW-1:0];
      end
    end
  end

  assign LEDS           = leds_q;
  assign irq            = irq_q;
  assign bus.data_read  = data_read_q;
  assign bus.read_valid = read_valid_q;

endmodule

// File: tb/tb_dmio_gpio.sv
// Directed and randomized checks of dmio_gpio against a cycle-level behavioural model.
module tb_dmio_gpio;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic [7:0] leds;
  logic       irq;

  always #5 clk = ~clk;

  dmio_gpio_if #(.DATA_W(64), .ADDR_W(64)) bus ();

  dmio_gpio #(
    .DATA_W(64), .ADDR_W(64), .MEM_DEPTH(256), .IO_BASE(64'h1000),
    .N_LED(8), .N_SW(8), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .SW(sw), .LEDS(leds), .irq(irq)
  );

  int tests = 0;
  int fails = 0;

  // Reference state
  logic [63:0] m_ram [256];
  bit          m_ram_v [256];
  logic [7:0]  m_led, m_stable, m_edge, m_mask, m_s1, m_s2;
  int          m_run [8];
  bit          m_irq, m_rv, m_rd_known;
  logic [63:0] m_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_read(input logic [63:0] a, output bit known);
    logic [63:0] off;
    known = 1'b1;
    if (a < 64'd2048) begin
      known = m_ram_v[a[10:3]];
      return m_ram[a[10:3]];
    end
    if (a < 64'h1000) return 64'd0;
    off = (a - 64'h1000) >> 3;
    case (off)
      64'd0:   return {56'd0, m_led};
      64'd1:   return {56'd0, m_stable};
      64'd2:   return {56'd0, m_edge};
      64'd3:   return {56'd0, m_mask};
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [63:0] a, val, off;
    logic [7:0]  nstable, rise, clr;
    bit          known, nirq;
    a = bus.address;
    if (rst) begin
      m_led = 0; m_stable = 0; m_edge = 0; m_mask = 0; m_s1 = 0; m_s2 = 0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      m_irq = 0; m_rv = 0; m_rd = 0; m_rd_known = 1;
    end else begin
      val  = m_read(a, known);
      nirq = |(m_edge & m_mask);
      nstable = m_stable;
      for (int i = 0; i < 8; i++) begin
        if (m_s2[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == DC) begin
            nstable[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      rise = nstable & ~m_stable;
      clr  = 8'd0;
      if (bus.enable_write) begin
        if (a < 64'd2048) begin
          m_ram[a[10:3]]   = bus.data_write;
          m_ram_v[a[10:3]] = 1'b1;
        end else if (a >= 64'h1000) begin
          off = (a - 64'h1000) >> 3;
          if (off == 64'd0) m_led = bus.data_write[7:0];
          if (off == 64'd2) clr = bus.data_write[7:0];
          if (off == 64'd3) m_mask = bus.data_write[7:0];
        end
      end
      m_edge   = (m_edge & ~clr) | rise;
      m_stable = nstable;
      m_irq    = nirq;
      m_s2     = m_s1;
      m_s1     = sw;
      m_rv     = bus.enable_read;
      if (bus.enable_read) begin
        m_rd = val;
        m_rd_known = known;
      end
    end
  endtask

  task automatic cycle(input logic [63:0] a, input logic [63:0] wd, input bit we, input bit re);
    bus.address      = a;
    bus.data_write   = wd;
    bus.enable_write = we;
    bus.enable_read  = re;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("leds", {56'd0, leds}, {56'd0, m_led});
    chk("irq", {63'd0, irq}, {63'd0, m_irq});
    chk("read_valid", {63'd0, bus.read_valid}, {63'd0, m_rv});
    if (m_rd_known) chk("data_read", bus.data_read, m_rd);
  endtask

  task automatic idle();
    cycle(64'd0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [63:0] a);
    cycle(a, 64'd0, 1'b0, 1'b1);
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d);
    cycle(a, d, 1'b1, 1'b0);
  endtask

  initial begin
    logic [63:0] a, wd;
    int          idx;
    rst = 1'b1;
    sw  = 8'd0;
    bus.address = 64'd0; bus.data_write = 64'd0;
    bus.enable_write = 1'b0; bus.enable_read = 1'b0;
    idle();
    idle();
    chk("rst_leds", {56'd0, leds}, 64'd0);
    chk("rst_irq", {63'd0, irq}, 64'd0);
    chk("rst_rv", {63'd0, bus.read_valid}, 64'd0);
    chk("rst_rd", bus.data_read, 64'd0);
    rst = 1'b0;

    // LED register and load timing
    wr(64'h1000, 64'd7);
    chk("led7", {56'd0, leds}, 64'h07);
    rd(64'h1000);
    chk("led_rv", {63'd0, bus.read_valid}, 64'd1);
    chk("led_rd", bus.data_read, 64'd7);
    idle();
    chk("rv_pulse", {63'd0, bus.read_valid}, 64'd0);
    chk("rd_hold", bus.data_read, 64'd7);

    // RAM, hole, read-first
    wr(64'h0018, 64'hDEADBEEF_0000_0003);
    rd(64'h0018);
    chk("ram_rd", bus.data_read, 64'hDEADBEEF_0000_0003);
    rd(64'h0800);
    chk("hole_rd", bus.data_read, 64'd0);
    cycle(64'h0018, 64'd5, 1'b1, 1'b1);
    chk("read_first", bus.data_read, 64'hDEADBEEF_0000_0003);
    rd(64'h0018);
    chk("ram_new", bus.data_read, 64'd5);

    // Short glitch is filtered
    sw = 8'h01;
    idle();
    idle();
    sw = 8'h00;
    repeat (10) idle();
    rd(64'h1008);
    chk("glitch_stable", bus.data_read, 64'd0);
    rd(64'h1010);
    chk("glitch_edge", bus.data_read, 64'd0);

    // Debounce latency, edge capture and irq
    wr(64'h1018, 64'h04);
    sw = 8'h04;
    for (int i = 1; i <= 7; i++) begin
      rd(64'h1008);
      chk("stable_timing", bus.data_read, (i == 7) ? 64'd4 : 64'd0);
      chk("irq_timing", {63'd0, irq}, (i == 7) ? 64'd1 : 64'd0);
    end
    rd(64'h1010);
    chk("edge_set", bus.data_read, 64'h04);
    wr(64'h1010, 64'h04);
    chk("irq_lag", {63'd0, irq}, 64'd1);
    idle();
    chk("irq_fall", {63'd0, irq}, 64'd0);
    rd(64'h1010);
    chk("edge_clr", bus.data_read, 64'd0);

    // Rising edge coinciding with W1C: set wins
    sw = 8'h00;
    repeat (8) idle();
    sw = 8'h04;
    repeat (5) idle();
    wr(64'h1010, 64'h04);
    rd(64'h1010);
    chk("set_wins", bus.data_read, 64'h04);

    // Reset in the middle of a load and a store
    wr(64'h0040, 64'h0123_4567_89AB_CDEF);
    wr(64'h1000, 64'hFF);
    chk("leds_ff", {56'd0, leds}, 64'hFF);
    chk("irq_pre_rst", {63'd0, irq}, 64'd1);
    rst = 1'b1;
    rd(64'h0040);
    chk("rst_no_rv", {63'd0, bus.read_valid}, 64'd0);
    chk("rst_leds0", {56'd0, leds}, 64'd0);
    chk("rst_irq0", {63'd0, irq}, 64'd0);
    wr(64'h0040, 64'hBAD);
    rst = 1'b0;
    rd(64'h0040);
    chk("ram_kept", bus.data_read, 64'h0123_4567_89AB_CDEF);
    rd(64'h1010);
    chk("edge_rst", bus.data_read, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 16; i++) wr(64'(i * 8), {$urandom, $urandom});
    wr(64'd255 * 8, {$urandom, $urandom});
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
      rst = ($urandom_range(0, 79) == 0);
      case ($urandom_range(0, 3))
        0: begin
          idx = ($urandom_range(0, 16) == 16) ? 255 : int'($urandom_range(0, 15));
          a   = 64'(idx * 8 + int'($urandom_range(0, 7)));
        end
        1:       a = 64'd2048 + 64'($urandom_range(0, 2047));
        2:       a = 64'h1000 + 64'($urandom_range(0, 39));
        default: a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      endcase
      wd = {$urandom, $urandom};
      cycle(a, wd, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end
    rst = 1'b0;
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
